// File: rtl/ps2_mouse_cursor_tracker_pkg.sv
// Shared types for the PS/2 mouse cursor tracker: packet layout, framing FSM states, delta helper.
package mouse_pkg;

    localparam int unsigned PS2_MOUSE_BYTE0_SYNC_BIT = 3;
    localparam int unsigned POS_W                    = 10;
    localparam int unsigned DELTA_W                  = 10;

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        APPLY = 2'd3
    } mouse_trk_state_t;

    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic       sync_one;
        logic [2:0] btn;       // {middle,right,left}
    } mouse_byte0_t;

    typedef struct packed {
        mouse_byte0_t byte0;
        logic [7:0]   dx;
        logic [7:0]   dy;
    } mouse_packet_t;

    // 9-bit two's complement movement, widened by one bit so its negation always fits.
    function automatic logic signed [DELTA_W-1:0] mouse_delta(input logic sign, input logic [7:0] mag);
        return {sign, sign, mag};
    endfunction

endpackage

// File: rtl/ps2_mouse_axis_accum.sv
// One cursor axis: holds the position and, on apply, adds a signed delta and clamps to 0..MAX.
module ps2_mouse_axis_accum
    import mouse_pkg::*;
#(
    parameter int unsigned MAX  = 629,
    parameter int unsigned INIT = 100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_apply,
    input  logic                      i_zero,
    input  logic signed [DELTA_W-1:0] i_delta,
    output logic [POS_W-1:0]          o_pos
);

    localparam int unsigned            SUM_W  = 12;
    localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(MAX);
    localparam logic [POS_W-1:0]       MAX_P  = POS_W'(MAX);
    localparam logic [POS_W-1:0]       INIT_P = POS_W'(INIT);

    logic [POS_W-1:0]        r_pos;
    logic [POS_W-1:0]        w_pos_nxt;
    logic signed [SUM_W-1:0] w_delta;
    logic signed [SUM_W-1:0] w_sum;

    // Widen, add and saturate; the sum range never exceeds 12-bit signed.
    always_comb begin
        w_delta   = i_zero ? SUM_W'(0) : SUM_W'($signed(i_delta));
        w_sum     = $signed(SUM_W'(r_pos)) + w_delta;
        w_pos_nxt = r_pos;
        if (w_sum[SUM_W-1]) begin
            w_pos_nxt = '0;
        end else if (w_sum > MAX_S) begin
            w_pos_nxt = MAX_P;
        end else begin
            w_pos_nxt = w_sum[POS_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= INIT_P;
        end else if (i_apply) begin
            r_pos <= w_pos_nxt;
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/ps2_mouse_cursor_tracker.sv
// Frames the mouse ps2rx byte stream into 3-byte packets and tracks a clamped cursor plus buttons.
module ps2_mouse_cursor_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned CURSOR_SIZE = 11,
    parameter int unsigned INIT_X      = 100,
    parameter int unsigned INIT_Y      = 100,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rx_done_tick,
    input  logic [7:0]       rx_dout,
    output logic [POS_W-1:0] cursor_x,
    output logic [POS_W-1:0] cursor_y,
    output logic [2:0]       buttons,
    output logic             packet_valid,
    output logic             sync_err
);

    localparam int unsigned      MAX_X    = SCREEN_W - CURSOR_SIZE;
    localparam int unsigned      MAX_Y    = SCREEN_H - CURSOR_SIZE;
    localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    mouse_trk_state_t r_state, w_state_nxt;
    mouse_packet_t    r_pkt, w_pkt_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [2:0]       r_buttons;
    logic             r_packet_valid;
    logic             r_sync_err;
    logic             r_err_defer;
    logic             w_sync_err_nxt;
    logic             w_err_defer_nxt;
    logic             w_sync_ok;
    logic             w_apply;
    logic signed [DELTA_W-1:0] w_dx;
    logic signed [DELTA_W-1:0] w_dy_neg;
    logic [POS_W-1:0] w_pos_x;
    logic [POS_W-1:0] w_pos_y;

    assign w_sync_ok = rx_dout[PS2_MOUSE_BYTE0_SYNC_BIT];
    assign w_apply   = en && (r_state == APPLY) && r_pkt.byte0.sync_one;
    assign w_dx      = mouse_delta(r_pkt.byte0.x_sign, r_pkt.dx);
    assign w_dy_neg  = -mouse_delta(r_pkt.byte0.y_sign, r_pkt.dy);

    // Framing FSM; the timer only advances while waiting for byte1/byte2.
    always_comb begin
        w_state_nxt     = r_state;
        w_pkt_nxt       = r_pkt;
        w_timer_nxt     = '0;
        w_sync_err_nxt  = 1'b0;
        w_err_defer_nxt = 1'b0;
        if (!en) begin
            w_state_nxt = BYTE0;
        end else begin
            case (r_state)
                BYTE0: begin
                    if (rx_done_tick) begin
                        if (w_sync_ok) begin
                            w_pkt_nxt.byte0 = mouse_byte0_t'(rx_dout);
                            w_state_nxt     = BYTE1;
                        end else begin
                            w_sync_err_nxt = 1'b1;
                        end
                    end
                end
                BYTE1: begin
                    if (rx_done_tick) begin
                        w_pkt_nxt.dx = rx_dout;
                        w_state_nxt  = BYTE2;
                    end else if (r_timer == TMR_LAST) begin
                        w_state_nxt    = BYTE0;
                        w_sync_err_nxt = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TMR_W'(1);
                    end
                end
                BYTE2: begin
                    if (rx_done_tick) begin
                        w_pkt_nxt.dy = rx_dout;
                        w_state_nxt  = APPLY;
                    end else if (r_timer == TMR_LAST) begin
                        w_state_nxt    = BYTE0;
                        w_sync_err_nxt = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TMR_W'(1);
                    end
                end
                APPLY: begin
                    // A byte arriving here opens the next packet; a bad one reports a cycle late
                    // so it never collides with this packet's packet_valid pulse.
                    w_state_nxt = BYTE0;
                    if (rx_done_tick) begin
                        if (w_sync_ok) begin
                            w_pkt_nxt.byte0 = mouse_byte0_t'(rx_dout);
                            w_state_nxt     = BYTE1;
                        end else begin
                            w_err_defer_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = BYTE0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= BYTE0;
            r_pkt          <= '0;
            r_timer        <= '0;
            r_buttons      <= '0;
            r_packet_valid <= 1'b0;
            r_sync_err     <= 1'b0;
            r_err_defer    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pkt          <= w_pkt_nxt;
            r_timer        <= w_timer_nxt;
            r_packet_valid <= w_apply;
            r_sync_err     <= w_sync_err_nxt | r_err_defer;
            r_err_defer    <= w_err_defer_nxt;
            if (w_apply) begin
                r_buttons <= r_pkt.byte0.btn;
            end
        end
    end

    ps2_mouse_axis_accum #(
        .MAX  (MAX_X),
        .INIT (INIT_X)
    ) u_axis_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_apply (w_apply),
        .i_zero  (r_pkt.byte0.x_ovf),
        .i_delta (w_dx),
        .o_pos   (w_pos_x)
    );

    // Screen y grows downward, so mouse-up (positive dy) must decrease y.
    ps2_mouse_axis_accum #(
        .MAX  (MAX_Y),
        .INIT (INIT_Y)
    ) u_axis_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_apply (w_apply),
        .i_zero  (r_pkt.byte0.y_ovf),
        .i_delta (w_dy_neg),
        .o_pos   (w_pos_y)
    );

    assign cursor_x     = w_pos_x;
    assign cursor_y     = w_pos_y;
    assign buttons      = r_buttons;
    assign packet_valid = r_packet_valid;
    assign sync_err     = r_sync_err;

endmodule

// File: tb/tb_ps2_mouse_cursor_tracker.sv
// Self-checking bench: directed corner cases plus random packets against a packet-level cursor model.
module tb_ps2_mouse_cursor_tracker;

    localparam int unsigned T_CYC = 200;
    localparam int          MAX_X = 640 - 11;
    localparam int          MAX_Y = 480 - 11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       tick;
    logic [7:0] dout;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;
    logic [2:0] buttons;
    logic       packet_valid;
    logic       sync_err;

    int n_vec = 0;
    int n_mis = 0;
    int ref_x = 100;
    int ref_y = 100;
    int ref_btn = 0;

    always #5 clk = ~clk;

    ps2_mouse_cursor_tracker #(
        .SCREEN_W    (640),
        .SCREEN_H    (480),
        .CURSOR_SIZE (11),
        .INIT_X      (100),
        .INIT_Y      (100),
        .TIMEOUT_CYC (T_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .rx_done_tick (tick),
        .rx_dout      (dout),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .buttons      (buttons),
        .packet_valid (packet_valid),
        .sync_err     (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Packet-level reference: decode the three bytes and move the cursor.
    function automatic void model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx;
        int dy;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        if (b0[6]) dx = 0;
        if (b0[7]) dy = 0;
        ref_x   = clamp(ref_x + dx, MAX_X);
        ref_y   = clamp(ref_y - dy, MAX_Y);
        ref_btn = int'(b0[2:0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"}, cursor_x, ref_x);
        check({tag, "_y"}, cursor_y, ref_y);
        check({tag, "_btn"}, buttons, ref_btn);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick = 1'b1;
        dout = b;
        step();
        tick = 1'b0;
        dout = 8'($urandom);
    endtask

    // Called in the APPLY cycle, right after byte2 was taken.
    task automatic expect_apply(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        check({tag, "_pv_early"}, packet_valid, 0);
        model_apply(b0, b1, b2);
        step();
        check({tag, "_pv"}, packet_valid, 1);
        check({tag, "_se_quiet"}, sync_err, 0);
        check_pos(tag);
    endtask

    task automatic send_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int gap);
        send_byte(b0);
        check({tag, "_b0_se"}, sync_err, 0);
        idle(gap);
        send_byte(b1);
        idle(gap);
        send_byte(b2);
        expect_apply(tag, b0, b1, b2);
        step();
        check({tag, "_pv_pulse"}, packet_valid, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        logic got_se;
        logic [7:0] b0, b1, b2, bad;

        rst_n = 1'b0;
        en    = 1'b0;
        tick  = 1'b0;
        dout  = 8'h00;
        idle(3);
        check("rst_x", cursor_x, 100);
        check("rst_y", cursor_y, 100);
        check("rst_btn", buttons, 0);
        check("rst_pv", packet_valid, 0);
        check("rst_se", sync_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        en = 1'b1;
        step();

        // Basic packet
        send_packet("t1", 8'h08, 8'h05, 8'h03, 0);
        check("t1_x_abs", cursor_x, 105);
        check("t1_y_abs", cursor_y, 97);

        // Low clamps, then high clamps
        send_packet("t2a", 8'h18, 8'h00, 8'hFF, 1);
        check("t2_x0", cursor_x, 0);
        check("t2_y0", cursor_y, 0);
        send_packet("t2b", 8'h18, 8'hF0, 8'h00, 0);
        check("t2_xlo", cursor_x, 0);
        send_packet("t2c", 8'h08, 8'hFF, 8'h00, 2);
        send_packet("t2d", 8'h08, 8'hFF, 8'h00, 0);
        send_packet("t2e", 8'h08, 8'h73, 8'h00, 1);
        check("t2_x625", cursor_x, 625);
        send_packet("t2f", 8'h08, 8'h7F, 8'h00, 0);
        check("t2_xmax", cursor_x, MAX_X);
        send_packet("t2g", 8'h28, 8'h00, 8'h00, 0);
        send_packet("t2h", 8'h28, 8'h00, 8'h00, 3);
        check("t2_ymax", cursor_y, MAX_Y);
        send_packet("t2i", 8'h18, 8'h00, 8'h00, 0);
        check("t2_x373", cursor_x, 373);

        // Bad byte0 then a good packet
        send_byte(8'h00);
        check("t3_se", sync_err, 1);
        step();
        check("t3_se_pulse", sync_err, 0);
        send_packet("t3", 8'h09, 8'h01, 8'h01, 0);
        check("t3_x_abs", cursor_x, 374);
        check("t3_y_abs", cursor_y, 468);
        check("t3_btn_abs", buttons, 1);

        // Overflow flags zero their axis only
        send_packet("t4a", 8'h48, 8'hFF, 8'h02, 0);
        check("t4_x_hold", cursor_x, 374);
        check("t4_y_abs", cursor_y, 466);
        send_packet("t4b", 8'h8D, 8'h05, 8'h7F, 1);

        // Timeout mid-packet
        send_byte(8'h08);
        send_byte(8'h05);
        cnt    = 1;
        got_se = 1'b0;
        while (cnt <= int'(T_CYC) + 8) begin
            if (sync_err) begin
                got_se = 1'b1;
                break;
            end
            step();
            cnt++;
        end
        check("t5_timeout_seen", got_se, 1);
        check("t5_timeout_lat", cnt, T_CYC + 1);
        check("t5_pv_none", packet_valid, 0);
        step();
        check("t5_se_pulse", sync_err, 0);
        check_pos("t5_hold");
        send_packet("t5", 8'h08, 8'h01, 8'h00, 0);

        // Tick landing exactly on the expiry cycle wins
        send_byte(8'h08);
        idle(T_CYC - 1);
        send_byte(8'h03);
        check("t5b_no_se", sync_err, 0);
        send_byte(8'h00);
        expect_apply("t5b", 8'h08, 8'h03, 8'h00);
        step();

        // Byte0 arriving in the APPLY cycle opens the next packet
        send_byte(8'h0A);
        send_byte(8'h01);
        send_byte(8'h00);
        model_apply(8'h0A, 8'h01, 8'h00);
        send_byte(8'h08);
        check("t7_pv", packet_valid, 1);
        check_pos("t7a");
        send_byte(8'h03);
        send_byte(8'h00);
        expect_apply("t7b", 8'h08, 8'h03, 8'h00);
        step();

        // en dropped mid-packet discards it silently; ticks ignored while low
        send_byte(8'h08);
        send_byte(8'h05);
        en = 1'b0;
        step();
        send_byte(8'h09);
        for (int i = 0; i < 3; i++) begin
            check("t6_en_se", sync_err, 0);
            check("t6_en_pv", packet_valid, 0);
            step();
        end
        check_pos("t6_en_hold");
        en = 1'b1;
        step();
        send_packet("t6e", 8'h08, 8'h02, 8'h00, 0);

        // Async reset mid-packet
        send_byte(8'h08);
        send_byte(8'h05);
        #2;
        rst_n = 1'b0;
        #1;
        ref_x   = 100;
        ref_y   = 100;
        ref_btn = 0;
        check_pos("t6_arst");
        check("t6_arst_pv", packet_valid, 0);
        check("t6_arst_se", sync_err, 0);
        #3;
        rst_n = 1'b1;
        step();
        send_packet("t6r", 8'h08, 8'h01, 8'h01, 0);

        // Random packets with occasional junk byte0
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                bad = 8'($urandom) & 8'hF7;
                send_byte(bad);
                check("rnd_bad_se", sync_err, 1);
                step();
                check("rnd_bad_pulse", sync_err, 0);
            end
            b0 = 8'($urandom) | 8'h08;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            send_packet("rnd", b0, b1, b2, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
